check_node_serial: RTL

Serial, parametrised min-sum check-node processor for the LDPC decoder. It accepts the DEG variable-to-check messages of one check node one per cycle and tracks min1, min2, the index of min1 and the sign parity. It then emits the DEG extrinsic check-to-variable messages one per cycle, with each output excluding its own input. It replaces fixed-degree combinational min blocks in the check-node update path, adding arbitrary degree, offset correction, saturation and valid/ready flow control.

---
 rtl/check_node_serial_if.sv | 26 ++
 rtl/check_node_serial.sv | 130 +++++++++++++
 2 files changed

// File: rtl/check_node_serial_if.sv
// Stream bundle for the serial min-sum check node: one valid/ready input
// stream of variable-to-check messages and one of check-to-variable messages.
interface check_node_serial_if #(
  parameter int W = 16
);
  // Handshake: a beat transfers on a rising clock edge where valid and ready
  // are both high; a source holds valid and its payload until that edge.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_msg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_msg;
  logic         out_last;
  logic         dbg_emit;

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_last, dbg_emit
  );

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_last, dbg_emit
  );
endinterface

// File: rtl/check_node_serial.sv
// Serial offset-min-sum check node: collects DEG messages tracking min1/min2,
// the min1 index and sign parity, then emits DEG extrinsic messages.
module check_node_serial #(
  parameter int INT    = 8,
  parameter int FRAC   = 8,
  parameter int DEG    = 5,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  check_node_serial_if.slave bus
);

  localparam int W  = INT + FRAC;
  localparam int CW = (DEG > 2) ? $clog2(DEG) : 1;
  localparam logic [W-2:0]  MAG_MAX = '1;
  localparam logic [W-2:0]  OFF     = (W-1)'(OFFSET);
  localparam logic [CW-1:0] LAST    = CW'(DEG - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_idx;
  logic [W-2:0]    r_min1;
  logic [W-2:0]    r_min2;
  logic            r_parity;
  logic [DEG-1:0]  r_sign;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_cnt_last;
  logic            w_in_neg;
  logic [W-2:0]    w_in_low;
  logic [W-2:0]    w_in_mag;
  logic [W-2:0]    w_mag;
  logic [W-2:0]    w_corr;
  logic            w_out_neg;

  assign w_cnt_last = (r_cnt == LAST);
  assign w_in_fire  = bus.in_valid && (r_state == S_COLLECT) && !rst;
  assign w_out_fire = bus.out_ready && (r_state == S_EMIT) && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; both readies are held low during reset
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_in_ready = !rst;
        if (w_in_fire && w_cnt_last) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_out_valid = !rst;
        if (w_out_fire && w_cnt_last) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // |in_msg| on W-1 bits; the most negative code has no positive twin and
  // saturates to the largest magnitude.
  assign w_in_neg = bus.in_msg[W-1];
  assign w_in_low = bus.in_msg[W-2:0];
  always_comb begin
    w_in_mag = w_in_low;
    if (w_in_neg) begin
      if (w_in_low == '0) w_in_mag = MAG_MAX;
      else                w_in_mag = ~w_in_low + 1'b1;
    end
  end

  // Datapath: running minima during collection, frame reinit on the last output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_min1   <= MAG_MAX;
      r_min2   <= MAG_MAX;
      r_parity <= 1'b0;
      r_sign   <= '0;
    end else if (w_in_fire) begin
      r_sign[r_cnt] <= w_in_neg;
      r_parity      <= r_parity ^ w_in_neg;
      if (w_in_mag < r_min1) begin
        r_min2 <= r_min1;
        r_min1 <= w_in_mag;
        r_idx  <= r_cnt;
      end else if (w_in_mag < r_min2) begin
        r_min2 <= w_in_mag;
      end
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
    end else if (w_out_fire) begin
      if (w_cnt_last) begin
        r_cnt    <= '0;
        r_idx    <= '0;
        r_min1   <= MAG_MAX;
        r_min2   <= MAG_MAX;
        r_parity <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Extrinsic output: exclude own magnitude via min2, own sign via parity
  assign w_mag     = (r_cnt == r_idx) ? r_min2 : r_min1;
  assign w_corr    = (w_mag > OFF) ? (w_mag - OFF) : '0;
  assign w_out_neg = r_parity ^ r_sign[r_cnt];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_msg   = w_out_neg ? (W'(0) - {1'b0, w_corr}) : {1'b0, w_corr};
  assign bus.out_last  = w_cnt_last;
  assign bus.dbg_emit  = (r_state == S_EMIT);

endmodule
